data_ram_resp: RTL and testbench
================================

DATA_RAM_RESP -- requirements
Module: data_ram_resp

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DEPTH_LOG2, 10, word-address bits (array = 2^DEPTH_LOG2 x 32-bit words)
- WAIT_CYCLES, 1, extra wait states per access (0..15)
REQ-002 Ports SHALL be (name direction width meaning):
- clk input 1 sole clock, rising edge
- rst input 1 synchronous, active-high reset (RstEnable = 1)
- ce_i input 1 request valid (chip enable from MEM stage)
- we_i input 1 1 = write, 0 = read
- addr_i input 32 byte address
- sel_i input 4 byte-lane enables, big-endian (sel_i[3] = bits 31:24 = byte offset 0)
- data_i input 32 write data, lane-replicated by requester
- data_o output 32 read data, valid in RESP only
- stall_o output 1 pipeline hold request to ctrl
- busy_o output 1 state != IDLE, for debug/observability

Function
REQ-003 Word index SHALL be addr_i[DEPTH_LOG2+1:2]; addr_i[1:0] and upper bits SHALL be ignored (aliasing wraps).
REQ-004 FSM states SHALL be IDLE, WAIT, RESP.
REQ-005 In IDLE with ce_i=1, the block SHALL latch we_i, index, sel_i, data_i; go to WAIT with counter = WAIT_CYCLES-1 when WAIT_CYCLES>0, else go directly to RESP.
REQ-006 In WAIT, the counter SHALL decrement each cycle; at 0, next state SHALL be RESP.
REQ-007 On the transition into RESP, a latched write SHALL update exactly the lanes with sel=1; a latched read SHALL register the full word into data_o.
REQ-008 In RESP, next state SHALL be IDLE unconditionally; a request present in that cycle SHALL NOT be captured.
REQ-009 stall_o SHALL equal ce_i AND (state != RESP), combinationally.
REQ-010 Access latency SHALL be WAIT_CYCLES+2 cycles from the first ce_i cycle to the RESP cycle inclusive.
REQ-011 data_o SHALL hold its last value outside RESP; on writes, data_o SHALL be unchanged.
REQ-012 If ce_i drops while in WAIT (pipeline flush), the block SHALL return to IDLE next cycle, committing no write and leaving data_o unchanged.
REQ-013 Write with sel_i=4'b0000 SHALL complete normally with no array change.
REQ-014 Request fields SHALL be sampled only in IDLE; changes during WAIT SHALL be ignored.
REQ-015 Back-to-back accesses SHALL see prior writes (read after RESP of a write returns merged data).

Reset
REQ-016 With rst=1 at a clock edge: state SHALL become IDLE, counter 0, data_o 32'h0, latched request cleared; stall_o SHALL be 0 while rst=1.
REQ-017 Reset mid-access SHALL abort it with no array write; array contents SHALL NOT be reset.

Structure
REQ-018 State encodings and lane-position constants SHALL be defined in the shared defines file alongside the existing bus-width and enable macros.
REQ-019 The storage array SHALL be a sub-module data_ram_bank (per-lane write enable, synchronous write, combinational read); FSM and request latch SHALL stay in data_ram_resp.

Verification
REQ-020 Bench SHALL cover:
- WAIT_CYCLES=1: write 0x11223344 sel 1111 addr 0x10, then read 0x10 -> stall_o high 2 cycles each, data_o=0x11223344 in RESP.
- Byte write 0xAAAAAAAA sel 0100 addr 0x11 over 0x11223344 -> read returns 0x11AA3344.
- WAIT_CYCLES=0: read -> stall_o high 1 cycle, RESP in 2nd cycle.
- Flush: write 0xDEADBEEF, drop ce_i in WAIT -> IDLE next cycle, later read returns old contents.
- rst during WAIT of write -> data_o=0, stall_o=0, contents unchanged.
- Alias: write addr 0x1000 with DEPTH_LOG2=10 -> read addr 0x0 returns same word.

Source files
------------

// File: rtl/data_ram_resp_pkg.sv
// Shared types and constants for the data RAM responder: FSM encodings,
// lane geometry and the latched request record.
package data_ram_resp_pkg;

    localparam int WORD_W    = 32;
    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 4;
    localparam int CNT_W     = 4;

    // Big-endian lane positions: sel bit carrying each byte offset.
    localparam int LANE_BYTE0 = 3;
    localparam int LANE_BYTE1 = 2;
    localparam int LANE_BYTE2 = 1;
    localparam int LANE_BYTE3 = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                 we;
        logic [NUM_LANES-1:0] sel;
        logic [WORD_W-1:0]    data;
    } req_t;

endpackage

// File: rtl/data_ram_bank.sv
// Word-wide storage array with per-lane write enables.
// Latency: synchronous write, combinational read.
// Backpressure: none; the caller sequences every access.
module data_ram_bank
    import data_ram_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic [NUM_LANES-1:0]  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Lane l of sel covers bits [8l+7:8l], so sel[3] is the MSB byte.
    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (we[l]) begin
                mem[addr][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_ram_resp.sv
// Data RAM responder: latches a MEM-stage request, waits, then commits/reads.
// Latency: WAIT_CYCLES+2 cycles from first ce_i cycle to RESP inclusive.
// Backpressure: stall_o holds the pipeline while ce_i is high outside RESP.
module data_ram_resp
    import data_ram_resp_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce_i,
    input  logic                 we_i,
    input  logic [31:0]          addr_i,
    input  logic [NUM_LANES-1:0] sel_i,
    input  logic [WORD_W-1:0]    data_i,
    output logic [WORD_W-1:0]    data_o,
    output logic                 stall_o,
    output logic                 busy_o
);

    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    req_t                  req_q, req_live, req_eff;
    logic [DEPTH_LOG2-1:0] idx_q, idx_live, idx_eff;
    logic                  commit;
    logic [NUM_LANES-1:0]  bank_we;
    logic [WORD_W-1:0]     bank_rdata;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};

    assign idx_live = addr_i[DEPTH_LOG2+1:2];
    assign req_live = '{we: we_i, sel: sel_i, data: data_i};

    // With no wait states the commit edge is also the capture edge,
    // so IDLE works straight from the live request.
    assign req_eff = (state_q == ST_IDLE) ? req_live : req_q;
    assign idx_eff = (state_q == ST_IDLE) ? idx_live : idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ce_i) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (!ce_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        stall_o = ce_i && (state_q != ST_RESP) && !rst;
        busy_o  = (state_q != ST_IDLE);
        commit  = (state_d == ST_RESP) && !rst;
        bank_we = (commit && req_eff.we) ? req_eff.sel : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q  <= '0;
            idx_q  <= '0;
            data_o <= '0;
        end else begin
            if (state_q == ST_IDLE && ce_i) begin
                req_q <= req_live;
                idx_q <= idx_live;
            end
            if (commit && !req_eff.we) begin
                data_o <= bank_rdata;
            end
        end
    end

    data_ram_bank #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .addr  (idx_eff),
        .wdata (req_eff.data),
        .rdata (bank_rdata)
    );

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed bench for data_ram_resp: one instance with one wait state, one with none.
module tb_data_ram_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_a, we_a, ce_b, we_b;
    logic [31:0] addr_a, din_a, dout_a, addr_b, din_b, dout_b;
    logic [3:0]  sel_a, sel_b;
    logic        stall_a, busy_a, stall_b, busy_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_ram_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .ce_i(ce_a), .we_i(we_a), .addr_i(addr_a),
        .sel_i(sel_a), .data_i(din_a), .data_o(dout_a), .stall_o(stall_a), .busy_o(busy_a)
    );

    data_ram_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .ce_i(ce_b), .we_i(we_b), .addr_i(addr_b),
        .sel_i(sel_b), .data_i(din_b), .data_o(dout_b), .stall_o(stall_b), .busy_o(busy_b)
    );

    task automatic drive(input bit use_b, input logic ce, input logic we,
                         input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] data);
        if (use_b) begin
            ce_b = ce; we_b = we; addr_b = addr; sel_b = sel; din_b = data;
        end else begin
            ce_a = ce; we_a = we; addr_a = addr; sel_a = sel; din_a = data;
        end
    endtask

    // Holds ce high until the responder drops stall (the RESP cycle), then releases it.
    task automatic access(input bit use_b, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] data,
                          input int exp_stall, input logic [31:0] exp_dout, input string tag);
        int   stalls = 0;
        bit   done   = 0;
        logic st, bz;
        logic [31:0] dv;
        @(negedge clk);
        drive(use_b, 1'b1, we, addr, sel, data);
        for (int c = 0; c < 20 && !done; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            st = use_b ? stall_b : stall_a;
            if (st) stalls++;
            else    done = 1;
        end
        dv = use_b ? dout_b : dout_a;
        bz = use_b ? busy_b : busy_a;
        n_cmp += 4;
        if (!done) begin
            n_bad++;
            $display("FAIL %s timeout: stall never dropped within 20 cycles", tag);
        end
        if (stalls !== exp_stall) begin
            n_bad++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", tag, stalls, exp_stall);
        end
        if (dv !== exp_dout) begin
            n_bad++;
            $display("FAIL %s data_o: got %h expected %h", tag, dv, exp_dout);
        end
        if (bz !== 1'b1) begin
            n_bad++;
            $display("FAIL %s busy_in_resp: got %b expected 1", tag, bz);
        end
        @(negedge clk);
        drive(use_b, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        bz = use_b ? busy_b : busy_a;
        n_cmp++;
        if (bz !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy_after_resp: got %b expected 0", tag, bz);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_cmp += 4;
        if (stall_a !== 1'b0) begin n_bad++; $display("FAIL reset_stall_a: got %b expected 0", stall_a); end
        if (stall_b !== 1'b0) begin n_bad++; $display("FAIL reset_stall_b: got %b expected 0", stall_b); end
        if (dout_a !== 32'h0) begin n_bad++; $display("FAIL reset_dout_a: got %h expected 0", dout_a); end
        if (busy_a !== 1'b0)  begin n_bad++; $display("FAIL reset_busy_a: got %b expected 0", busy_a); end
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_write_read();
        access(0, 1'b1, 32'h10, 4'b1111, 32'h11223344, 2, 32'h0,        "wr_full");
        access(0, 1'b0, 32'h10, 4'b1111, 32'h0,        2, 32'h11223344, "rd_full");
    endtask

    task automatic test_byte_write();
        access(0, 1'b1, 32'h11, 4'b0100, 32'hAAAAAAAA, 2, 32'h11223344, "wr_byte");
        access(0, 1'b0, 32'h10, 4'b1111, 32'h0,        2, 32'h11AA3344, "rd_byte");
    endtask

    task automatic test_sel_zero();
        access(0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 2, 32'h11AA3344, "wr_sel0");
        access(0, 1'b0, 32'h10, 4'b1111, 32'h0,        2, 32'h11AA3344, "rd_sel0");
    endtask

    task automatic test_wait0();
        access(1, 1'b1, 32'h40, 4'b1111, 32'h12345678, 1, 32'h0,        "w0_wr");
        access(1, 1'b0, 32'h40, 4'b1111, 32'h0,        1, 32'h12345678, "w0_rd");
    endtask

    task automatic test_flush();
        access(0, 1'b1, 32'h20, 4'b1111, 32'h55667788, 2, 32'h11AA3344, "wr_pre_flush");
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h20, 4'b1111, 32'hDEADBEEF);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h20, 4'b1111, 32'hDEADBEEF);
        #1;
        n_cmp += 2;
        if (busy_a !== 1'b1)  begin n_bad++; $display("FAIL flush_in_wait busy: got %b expected 1", busy_a); end
        if (stall_a !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b expected 0", stall_a); end
        @(negedge clk); #1;
        n_cmp += 2;
        if (busy_a !== 1'b0) begin n_bad++; $display("FAIL flush_idle busy: got %b expected 0", busy_a); end
        if (dout_a !== 32'h11AA3344) begin n_bad++; $display("FAIL flush_dout: got %h expected 11aa3344", dout_a); end
        access(0, 1'b0, 32'h20, 4'b1111, 32'h0, 2, 32'h55667788, "rd_post_flush");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h20, 4'b1111, 32'hCAFEF00D);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (stall_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stall: got %b expected 0", stall_a); end
        @(negedge clk); #1;
        n_cmp += 3;
        if (dout_a !== 32'h0) begin n_bad++; $display("FAIL rst_mid_dout: got %h expected 0", dout_a); end
        if (busy_a !== 1'b0)  begin n_bad++; $display("FAIL rst_mid_busy: got %b expected 0", busy_a); end
        if (stall_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stall_held: got %b expected 0", stall_a); end
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        access(0, 1'b0, 32'h20, 4'b1111, 32'h0, 2, 32'h55667788, "rd_post_rst");
    endtask

    task automatic test_field_change();
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h10, 4'b1111, 32'h0);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h20, 4'b1111, 32'h00000000);
        #1;
        n_cmp++;
        if (stall_a !== 1'b1) begin n_bad++; $display("FAIL chg_wait_stall: got %b expected 1", stall_a); end
        @(negedge clk); #1;
        n_cmp += 2;
        if (stall_a !== 1'b0) begin n_bad++; $display("FAIL chg_resp_stall: got %b expected 0", stall_a); end
        if (dout_a !== 32'h11AA3344) begin n_bad++; $display("FAIL chg_resp_dout: got %h expected 11aa3344", dout_a); end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        n_cmp++;
        if (busy_a !== 1'b0) begin n_bad++; $display("FAIL chg_no_capture busy: got %b expected 0", busy_a); end
        access(0, 1'b0, 32'h20, 4'b1111, 32'h0, 2, 32'h55667788, "rd_chg_0x20");
        access(0, 1'b0, 32'h10, 4'b1111, 32'h0, 2, 32'h11AA3344, "rd_chg_0x10");
    endtask

    task automatic test_alias();
        access(0, 1'b1, 32'h1000, 4'b1111, 32'h0BADF00D, 2, 32'h11AA3344, "wr_alias");
        access(0, 1'b0, 32'h0,    4'b1111, 32'h0,        2, 32'h0BADF00D, "rd_alias");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_sel_zero();
        test_wait0();
        test_flush();
        test_reset_mid();
        test_field_change();
        test_alias();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
